digit_serial_addsub: RTL



---
 rtl/digit_serial_addsub_if.sv | 29 ++
 rtl/digit_serial_addsub.sv | 111 +++++++++++
 2 files changed

// File: rtl/digit_serial_addsub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// Handshake: start is sampled only on a rising edge where ready=1, and a, b and sub are captured at that same edge.
// While busy=1, start is ignored. done pulses for one cycle when sum, carry_out and overflow have just been updated.
interface digit_serial_addsub_if #(
    parameter int N = 8
);
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         dbg_state;
    logic         dbg_sub;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, carry_out, overflow, dbg_state, dbg_sub
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, carry_out, overflow, dbg_state, dbg_sub
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement add/subtract: N-bit operands, D bits per clock, LSD first.
// The result registers update only on the completion cycle and hold their values in between.
module digit_serial_addsub #(
    parameter int N = 8,
    parameter int D = 1
) (
    input logic                  clk,
    input logic                  rst,
    digit_serial_addsub_if.slave bus
);
    localparam int L  = N / D;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_next;
    logic [N-1:0]  a_sh, b_sh, res_sh, res_next, sum_q;
    logic [CW-1:0] cnt;
    logic          cry, sub_q, cout_q, ovf_q, done_q;
    logic          accept, last;
    logic [D-1:0]  dsum;
    logic          c_msb_in, c_dig_out;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: if (cnt == CW'(L - 1)) begin
                last       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Ripple add of one digit; c_msb_in ends up as the carry into the digit's top bit.
    always_comb begin : ripple
        logic cc;
        cc       = cry;
        dsum     = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < D; i++) begin
            c_msb_in = cc;
            dsum[i]  = a_sh[i] ^ b_sh[i] ^ cc;
            cc       = (a_sh[i] & b_sh[i]) | (cc & (a_sh[i] ^ b_sh[i]));
        end
        c_dig_out = cc;
    end

    generate
        if (D == N) begin : g_single_digit
            assign res_next = dsum;
        end else begin : g_multi_digit
            assign res_next = {dsum, res_sh[N-1:D]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            cry    <= 1'b0;
            sub_q  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.sub ? ~bus.b : bus.b;
                cry   <= bus.sub;
                sub_q <= bus.sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> D;
                b_sh   <= b_sh >> D;
                res_sh <= res_next;
                cry    <= c_dig_out;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    sum_q  <= res_next;
                    cout_q <= c_dig_out;
                    ovf_q  <= c_msb_in ^ c_dig_out;
                end
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state;
    assign bus.dbg_sub   = sub_q;
endmodule
